// File: rtl/booth_pkg.sv
// Shared types and radix-4 Booth recoding for the sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Booth digits held as 3-bit two's complement so they read naturally in waves
    localparam logic [2:0] BD_ZERO = 3'b000;
    localparam logic [2:0] BD_P1   = 3'b001;
    localparam logic [2:0] BD_P2   = 3'b010;
    localparam logic [2:0] BD_M1   = 3'b111;
    localparam logic [2:0] BD_M2   = 3'b110;

    function automatic logic [2:0] booth_recode(input logic [2:0] win);
        logic [2:0] dig;
        dig = BD_ZERO;
        unique case (win)
            3'b000:  dig = BD_ZERO;
            3'b001:  dig = BD_P1;
            3'b010:  dig = BD_P1;
            3'b011:  dig = BD_P2;
            3'b100:  dig = BD_M2;
            3'b101:  dig = BD_M1;
            3'b110:  dig = BD_M1;
            3'b111:  dig = BD_ZERO;
            default: dig = BD_ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: d * a_ext for one recoded window.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       win,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+2:0] pp
);

    logic [WIDTH+2:0] a_sx;
    logic [2:0]       dig;

    assign a_sx = {a_ext[WIDTH+1], a_ext};

    always_comb begin
        dig = booth_recode(win);
        pp  = '0;
        unique case (dig)
            BD_ZERO: pp = '0;
            BD_P1:   pp = a_sx;
            BD_P2:   pp = a_sx << 1;
            BD_M1:   pp = -a_sx;
            BD_M2:   pp = -(a_sx << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int unsigned NDIG = WIDTH / 2 + 1;
    localparam int unsigned CW   = $clog2(NDIG + 1);
    localparam int unsigned AW   = 2 * WIDTH + 4;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : gen_bad_width
        $error("booth_mult_seq: WIDTH must be even and >= 4");
    end

    state_e             state_q, state_d;
    logic [WIDTH+1:0]   a_q, a_d;
    // b_ext with the implicit 0 appended below bit 0
    logic [WIDTH+2:0]   b_q, b_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [2:0]         win;
    logic [WIDTH+2:0]   pp;
    logic [AW-1:0]      pp_ext;
    logic [AW-1:0]      acc_sum;
    logic               last_dig;

    assign win      = b_q[{cnt_q, 1'b0} +: 3];
    assign pp_ext   = {{(WIDTH + 1){pp[WIDTH+2]}}, pp};
    assign acc_sum  = acc_q + (pp_ext << {cnt_q, 1'b0});
    assign last_dig = (cnt_q == CW'(NDIG - 1));

    booth_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .win   (win),
        .a_ext (a_q),
        .pp    (pp)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
                    b_d     = in_signed ? {{2{in_b[WIDTH-1]}}, in_b, 1'b0}
                                        : {2'b00, in_b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (last_dig) begin
                    p_d     = acc_sum[2*WIDTH-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StBusy);
    assign out_valid = (state_q == StDone);
    assign out_p     = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=8: directed corners, stalls, reset, random mix.
module tb_booth_mult_seq;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] p;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;

    int             errors = 0;
    int             checks = 0;
    logic [2*W-1:0] exp_q[$];
    bit             rnd_on = 1'b0;

    // Hand-computed products
    vec_t vecs [13] = '{
        '{8'h80, 8'h80, 1'b1, 16'h4000},
        '{8'hFF, 8'h01, 1'b1, 16'hFFFF},
        '{8'h7F, 8'h80, 1'b1, 16'hC080},
        '{8'hFF, 8'h02, 1'b0, 16'h01FE},
        '{8'hFF, 8'h02, 1'b1, 16'hFFFE},
        '{8'h80, 8'h7F, 1'b1, 16'hC080},
        '{8'h80, 8'h80, 1'b0, 16'h4000},
        '{8'h80, 8'hFF, 1'b1, 16'h0080},
        '{8'h00, 8'hFF, 1'b0, 16'h0000},
        '{8'h03, 8'hFD, 1'b1, 16'hFFF7},
        '{8'h0F, 8'h11, 1'b0, 16'h00FF},
        '{8'h7F, 8'h7F, 1'b1, 16'h3F01},
        '{8'hFF, 8'hFF, 1'b1, 16'h0001}
    };

    always #5 clk = ~clk;

    booth_mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per output handshake
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_product: got %h, required no product", out_p);
                end else begin
                    check("product", 32'(out_p), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Present operands once in_ready is seen; returns just after the accept edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] p, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        if (push) exp_q.push_back(p);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int             lat;
        logic [W-1:0]   ra, rb;
        logic           rs;
        logic [2*W-1:0] rp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_p", 32'(out_p), 32'd0);
        rst = 1'b0;

        // Unsigned max with latency measurement
        issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        wait_out(lat);
        check("latency_unsigned_max", 32'(lat), 32'd5);

        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, 1'b1);
        drain();

        // Backpressure: product held, no new accept while in DONE
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1);
        wait_out(lat);
        check("latency_stall", 32'(lat), 32'd5);
        in_valid = 1'b1;
        in_a     = 8'h77;
        in_b     = 8'h77;
        for (int i = 0; i < 10; i++) begin
            check("stall_out_p", 32'(out_p), 32'h03A8);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);

        // Reset two clocks after accept discards the transaction
        issue(8'h55, 8'h66, 1'b1, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_p", 32'(out_p), 32'd0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        issue(8'h03, 8'h05, 1'b0, 16'h000F, 1'b1);
        drain();

        // Random operands with random downstream stalls
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (rs) rp = $signed({{W{ra[W-1]}}, ra}) * $signed({{W{rb[W-1]}}, rb});
            else    rp = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            issue(ra, rb, rs, rp, 1'b1);
        end
        drain();
        rnd_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
